// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit. It tracks the destination tags of in-flight instructions, drives the
// ALU/store-data bypass selects and the load-use and multdiv stalls, and keeps the multdiv scoreboard.
module hazard_forward_unit #(
  parameter int unsigned AW         = 5,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned MD_LATENCY = 32,
  localparam int unsigned SW = $clog2(FWD_DEPTH + 1),
  localparam int unsigned CW = $clog2(MD_LATENCY + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          fd_valid_i,
  input  logic [AW-1:0] fd_rs_a_i,
  input  logic [AW-1:0] fd_rs_b_i,
  input  logic          fd_uses_a_i,
  input  logic          fd_uses_b_i,
  input  logic [AW-1:0] fd_rd_i,
  input  logic          fd_wr_en_i,
  input  logic          fd_is_load_i,
  input  logic          fd_is_store_i,
  input  logic          fd_is_md_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic [SW-1:0] dx_a_sel_o,
  output logic [SW-1:0] dx_b_sel_o,
  output logic          mem_sel_o,
  output logic          md_busy_o,
  output logic          md_done_o,
  output logic [AW-1:0] md_rd_o
);

  typedef struct packed {
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic          uses_a;
    logic          uses_b;
    logic [AW-1:0] rd;
    logic          wr_en;
    logic          is_load;
    logic          is_store;
  } tag_t;

  // Index 0 is DX; index k is post-execute stage k.
  tag_t          stage_q [FWD_DEPTH+1];
  tag_t          dx_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic [AW-1:0] md_rd_q, md_rd_d;
  logic          issue;
  logic          load_use;
  logic          md_stall;

  function automatic logic writes_reg(tag_t t, logic [AW-1:0] r);
    return t.wr_en && (t.rd != '0) && (t.rd == r);
  endfunction

  always_comb begin
    load_use = stage_q[0].is_load && stage_q[0].wr_en && (stage_q[0].rd != '0) && fd_valid_i &&
               ((fd_uses_a_i && (fd_rs_a_i == stage_q[0].rd)) ||
                (fd_uses_b_i && (fd_rs_b_i == stage_q[0].rd) && !fd_is_store_i));
  end

  always_comb begin
    md_stall = md_busy_o && fd_valid_i &&
               (fd_is_md_i ||
                ((md_rd_q != '0) && ((fd_uses_a_i && (fd_rs_a_i == md_rd_q)) ||
                                     (fd_uses_b_i && (fd_rs_b_i == md_rd_q)))) ||
                (fd_wr_en_i && (fd_rd_i == md_rd_q)));
  end

  always_comb begin
    stall_o = (load_use || md_stall) && !flush_i;
    issue   = fd_valid_i && !stall_o && !flush_i;
  end

  // Multdiv results return via the scoreboard, so they never claim a forwarding slot.
  always_comb begin
    dx_d = '0;
    if (issue) begin
      dx_d.rs_a     = fd_rs_a_i;
      dx_d.rs_b     = fd_rs_b_i;
      dx_d.uses_a   = fd_uses_a_i;
      dx_d.uses_b   = fd_uses_b_i;
      dx_d.rd       = fd_rd_i;
      dx_d.wr_en    = fd_wr_en_i && !fd_is_md_i;
      dx_d.is_load  = fd_is_load_i;
      dx_d.is_store = fd_is_store_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k <= int'(FWD_DEPTH); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= dx_d;
      for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  // Walk from the oldest stage down so the youngest matching producer wins.
  always_comb begin
    dx_a_sel_o = '0;
    dx_b_sel_o = '0;
    for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
      if (stage_q[0].uses_a && writes_reg(stage_q[k], stage_q[0].rs_a)) begin
        dx_a_sel_o = SW'(k);
      end
      if (stage_q[0].uses_b && writes_reg(stage_q[k], stage_q[0].rs_b)) begin
        dx_b_sel_o = SW'(k);
      end
    end
  end

  always_comb begin
    mem_sel_o = stage_q[1].is_store && stage_q[2].is_load &&
                writes_reg(stage_q[2], stage_q[1].rs_b);
  end

  always_comb begin
    md_rd_d  = md_rd_q;
    md_cnt_d = md_cnt_q;
    if (issue && fd_is_md_i) begin
      md_cnt_d = CW'(MD_LATENCY);
      md_rd_d  = fd_rd_i;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      md_cnt_q <= '0;
      md_rd_q  <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      md_rd_q  <= md_rd_d;
    end
  end

  assign md_busy_o = (md_cnt_q != '0);
  assign md_done_o = (md_cnt_q == CW'(1));
  assign md_rd_o   = md_rd_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus random instruction streams checked
// against an instruction-history reference model.
module tb_hazard_forward_unit;

  localparam int AW   = 5;
  localparam int FD   = 3;
  localparam int LAT  = 4;
  localparam int SW   = $clog2(FD + 1);

  logic          clk_i;
  logic          rst_ni;
  logic          fd_valid_i;
  logic [AW-1:0] fd_rs_a_i, fd_rs_b_i, fd_rd_i;
  logic          fd_uses_a_i, fd_uses_b_i, fd_wr_en_i;
  logic          fd_is_load_i, fd_is_store_i, fd_is_md_i, flush_i;
  logic          stall_o, mem_sel_o, md_busy_o, md_done_o;
  logic [SW-1:0] dx_a_sel_o, dx_b_sel_o;
  logic [AW-1:0] md_rd_o;

  hazard_forward_unit #(
    .AW        (AW),
    .FWD_DEPTH (FD),
    .MD_LATENCY(LAT)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fd_valid_i   (fd_valid_i),
    .fd_rs_a_i    (fd_rs_a_i),
    .fd_rs_b_i    (fd_rs_b_i),
    .fd_uses_a_i  (fd_uses_a_i),
    .fd_uses_b_i  (fd_uses_b_i),
    .fd_rd_i      (fd_rd_i),
    .fd_wr_en_i   (fd_wr_en_i),
    .fd_is_load_i (fd_is_load_i),
    .fd_is_store_i(fd_is_store_i),
    .fd_is_md_i   (fd_is_md_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .dx_a_sel_o   (dx_a_sel_o),
    .dx_b_sel_o   (dx_b_sel_o),
    .mem_sel_o    (mem_sel_o),
    .md_busy_o    (md_busy_o),
    .md_done_o    (md_done_o),
    .md_rd_o      (md_rd_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history of what entered DX, youngest first; [0] is DX, [k] is stage k.
  typedef struct {
    bit ld, st, ua, ub, we;
    int rs_a, rs_b, rd;
  } ins_t;

  ins_t hist[$];
  int   cyc;
  int   md_iss;
  int   md_rd_m;
  bit   e_stall, e_mem, e_busy, e_done;
  int   e_a, e_b;

  task automatic model_reset();
    ins_t bub;
    bub = '{default: 0};
    hist.delete();
    for (int i = 0; i <= FD; i++) hist.push_back(bub);
    cyc     = 0;
    md_iss  = -1000;
    md_rd_m = 0;
    e_stall = 0;
  endtask

  function automatic int producer(int r, bit used);
    if (!used) return 0;
    for (int k = 1; k <= FD; k++) begin
      if (hist[k].we && hist[k].rd != 0 && hist[k].rd == r) return k;
    end
    return 0;
  endfunction

  task automatic model_eval();
    ins_t dx;
    bit lu, ms;
    int d, rsa, rsb, rd;
    dx  = hist[0];
    rsa = int'(fd_rs_a_i);
    rsb = int'(fd_rs_b_i);
    rd  = int'(fd_rd_i);
    d   = cyc - md_iss;
    e_busy = (d >= 1) && (d <= LAT);
    e_done = (d == LAT);
    lu = dx.ld && dx.we && dx.rd != 0 && fd_valid_i &&
         ((fd_uses_a_i && rsa == dx.rd) || (fd_uses_b_i && rsb == dx.rd && !fd_is_store_i));
    ms = e_busy && fd_valid_i &&
         (fd_is_md_i || (md_rd_m != 0 && ((fd_uses_a_i && rsa == md_rd_m) ||
                                          (fd_uses_b_i && rsb == md_rd_m))) ||
          (fd_wr_en_i && rd == md_rd_m));
    e_stall = (lu || ms) && !flush_i;
    e_a = producer(dx.rs_a, dx.ua);
    e_b = producer(dx.rs_b, dx.ub);
    e_mem = hist[1].st && hist[2].ld && hist[2].we && hist[2].rd != 0 &&
            hist[2].rd == hist[1].rs_b;
  endtask

  task automatic model_step();
    ins_t n;
    bit issue;
    n = '{default: 0};
    issue = fd_valid_i && !e_stall && !flush_i;
    if (issue) begin
      n.rs_a = int'(fd_rs_a_i);
      n.rs_b = int'(fd_rs_b_i);
      n.rd   = int'(fd_rd_i);
      n.ua   = fd_uses_a_i;
      n.ub   = fd_uses_b_i;
      n.we   = fd_wr_en_i && !fd_is_md_i;
      n.ld   = fd_is_load_i;
      n.st   = fd_is_store_i;
      if (fd_is_md_i) begin
        md_iss  = cyc;
        md_rd_m = int'(fd_rd_i);
      end
    end
    hist.push_front(n);
    void'(hist.pop_back());
    cyc++;
  endtask

  // Compare at the falling edge, advance the model, return just after the next rising edge.
  task automatic cycle();
    @(negedge clk_i);
    model_eval();
    check_eq("stall", stall_o, e_stall);
    check_eq("dx_a_sel", dx_a_sel_o, e_a);
    check_eq("dx_b_sel", dx_b_sel_o, e_b);
    check_eq("mem_sel", mem_sel_o, e_mem);
    check_eq("md_busy", md_busy_o, e_busy);
    check_eq("md_done", md_done_o, e_done);
    check_eq("md_rd", md_rd_o, md_rd_m);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int rd, input int ra, input int rb, input bit ua,
                       input bit ub, input bit we, input bit ld, input bit st, input bit md,
                       input bit fl);
    fd_valid_i    = v;
    fd_rd_i       = AW'(rd);
    fd_rs_a_i     = AW'(ra);
    fd_rs_b_i     = AW'(rb);
    fd_uses_a_i   = ua;
    fd_uses_b_i   = ub;
    fd_wr_en_i    = we;
    fd_is_load_i  = ld;
    fd_is_store_i = st;
    fd_is_md_i    = md;
    flush_i       = fl;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_alu(input int rd, input int ra, input int rb);
    drive(1, rd, ra, rb, 1, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic drive_load(input int rd, input int base);
    drive(1, rd, base, 0, 1, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic drain(input int n);
    drive_idle();
    repeat (n) cycle();
  endtask

  bit r_v, r_ua, r_ub, r_we, r_ld, r_st, r_md;
  int r_rd, r_ra, r_rb, cls;

  initial begin
    rst_ni = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_a_sel", dx_a_sel_o, 0);
    check_eq("rst_b_sel", dx_b_sel_o, 0);
    check_eq("rst_mem_sel", mem_sel_o, 0);
    check_eq("rst_md_busy", md_busy_o, 0);
    check_eq("rst_md_done", md_done_o, 0);
    check_eq("rst_md_rd", md_rd_o, 0);
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;

    // add r3; add r4,r3,r3; reader of r3
    drive_alu(3, 1, 2);
    cycle();
    drive_alu(4, 3, 3);
    cycle();
    drive(1, 5, 3, 0, 1, 0, 1, 0, 0, 0, 0);
    check_eq("fwd1_a", dx_a_sel_o, 1);
    check_eq("fwd1_b", dx_b_sel_o, 1);
    cycle();
    drive_idle();
    check_eq("fwd2_a", dx_a_sel_o, 2);
    cycle();
    drain(4);

    // writes to r0 never forward
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    cycle();
    drive_alu(2, 0, 0);
    #2 check_eq("r0_stall", stall_o, 0);
    cycle();
    drive_idle();
    check_eq("r0_a", dx_a_sel_o, 0);
    check_eq("r0_b", dx_b_sel_o, 0);
    cycle();
    drain(4);

    // load-use stall then forward from stage 2
    drive_load(5, 1);
    cycle();
    drive_alu(1, 5, 2);
    #2 check_eq("lu_stall", stall_o, 1);
    cycle();
    #2 check_eq("lu_release", stall_o, 0);
    cycle();
    drive_idle();
    check_eq("lu_a", dx_a_sel_o, 2);
    check_eq("lu_b", dx_b_sel_o, 0);
    cycle();
    drain(4);

    // load then store of the loaded register: no stall, MW->XM select
    drive_load(5, 1);
    cycle();
    drive(1, 0, 1, 5, 1, 1, 0, 0, 1, 0, 0);
    #2 check_eq("st_nostall", stall_o, 0);
    cycle();
    drive_idle();
    cycle();
    check_eq("st_mem_sel", mem_sel_o, 1);
    cycle();
    drain(4);

    // multdiv scoreboard with dependent reader
    drive(1, 7, 1, 2, 1, 1, 1, 0, 0, 1, 0);
    cycle();
    drive_alu(1, 7, 0);
    for (int i = 1; i <= LAT; i++) begin
      #2;
      check_eq("md_stall", stall_o, 1);
      check_eq("md_busy_on", md_busy_o, 1);
      check_eq("md_done_t", md_done_o, (i == LAT) ? 1 : 0);
      check_eq("md_rd_t", md_rd_o, 7);
      cycle();
    end
    #2 check_eq("md_release", stall_o, 0);
    check_eq("md_busy_off", md_busy_o, 0);
    cycle();
    drain(4);

    // asynchronous reset in the middle of a multdiv
    drive(1, 6, 1, 2, 1, 1, 1, 0, 0, 1, 0);
    cycle();
    drive_idle();
    cycle();
    #1 rst_ni = 1'b0;
    #1;
    check_eq("arst_busy", md_busy_o, 0);
    check_eq("arst_done", md_done_o, 0);
    check_eq("arst_stall", stall_o, 0);
    check_eq("arst_md_rd", md_rd_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    drain(LAT + 2);

    // flush wins over a load-use stall
    drive_load(5, 1);
    cycle();
    drive(1, 1, 5, 2, 1, 1, 1, 0, 0, 0, 1);
    #2 check_eq("flush_stall", stall_o, 0);
    cycle();
    drive_idle();
    check_eq("flush_bubble_a", dx_a_sel_o, 0);
    cycle();
    drain(4);

    // random streams; a stalled instruction is held in decode
    for (int i = 0; i < 800; i++) begin
      if (!e_stall) begin
        r_v  = ($urandom_range(0, 9) < 8);
        r_rd = $urandom_range(0, 3);
        r_ra = $urandom_range(0, 3);
        r_rb = $urandom_range(0, 3);
        cls  = $urandom_range(0, 9);
        r_ld = 0; r_st = 0; r_md = 0;
        r_ua = 1; r_ub = 1; r_we = 1;
        if (cls <= 3) begin
          r_ua = $urandom_range(0, 1);
          r_ub = $urandom_range(0, 1);
          r_we = $urandom_range(0, 1);
        end else if (cls <= 5) begin
          r_ld = 1; r_ub = 0;
        end else if (cls <= 7) begin
          r_st = 1; r_we = 0;
        end else if (cls == 8) begin
          r_md = 1; r_we = $urandom_range(0, 1);
        end else begin
          r_ua = $urandom_range(0, 1);
          r_ub = $urandom_range(0, 1);
          r_we = $urandom_range(0, 1);
          r_ld = $urandom_range(0, 1);
          r_st = $urandom_range(0, 1);
        end
      end
      drive(r_v, r_rd, r_ra, r_rb, r_ua, r_ub, r_we, r_ld, r_st, r_md,
            ($urandom_range(0, 9) == 0));
      cycle();
    end
    drain(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
